fetch_top: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline latch of the MIPS pipeline.
- Holds the PC and an instruction memory that the debug unit loads.
- Selects the next PC from the redirect information produced by the decode stage.
- Presents the registered instruction and PC+1 to decode, honouring stall, flush, halt and debug step-enable.

---
 rtl/mips_pkg.sv | 15 +
 rtl/instr_memory.sv | 28 ++
 rtl/fetch_top.sv | 108 ++++++++++
 tb/tb_fetch_top.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: next-PC select encodings, NOP word and default datapath width.
package mips_pkg;

  localparam int NB_DATA_DFLT = 32;

  localparam logic [NB_DATA_DFLT-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    PC_SRC_SEQ    = 2'b00,
    PC_SRC_BRANCH = 2'b01,
    PC_SRC_JUMP   = 2'b10,
    PC_SRC_REG    = 2'b11
  } pc_src_t;

endpackage

// File: rtl/instr_memory.sv
// Instruction store: combinational read, one-clock write; a same-cycle read of the written word sees old data.
// No flow control; the write port is owned by the debug unit.
module instr_memory
  import mips_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DFLT,
  parameter int NB_ADDR = 10
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [NB_ADDR-1:0] wr_addr,
  input  logic [NB_DATA-1:0] wr_data,
  input  logic [NB_ADDR-1:0] rd_addr,
  output logic [NB_DATA-1:0] rd_data
);

  logic [NB_DATA-1:0] mem [2**NB_ADDR];

  // Contents survive reset so a loaded program outlives a restart.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fetch_top.sv
// MIPS fetch stage + IF/ID latch; instruction_o/pc_decode_o follow the fetch by one clock.
// halt > enable_i=0 > stall > redirect > sequential; define DELAY_SLOT_EN to keep the slot instead of flushing.
module fetch_top
  import mips_pkg::*;
#(
  parameter int                 NB_DATA   = NB_DATA_DFLT,
  parameter int                 NB_ADDR   = 10,
  parameter logic [NB_DATA-1:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               enable_i,
  input  logic               stall,
  input  logic               pc_branch_or_jump,
  input  logic [1:0]         pc_src,
  input  logic [NB_DATA-1:0] address_jump,
  input  logic [NB_DATA-1:0] address_branch,
  input  logic [NB_DATA-1:0] address_register,
  input  logic               halt_signal,
  input  logic               imem_wr_en_i,
  input  logic [NB_ADDR-1:0] imem_wr_addr_i,
  input  logic [NB_DATA-1:0] imem_wr_data_i,
  output logic [NB_DATA-1:0] instruction_o,
  output logic [NB_DATA-1:0] pc_decode_o,
  output logic [NB_DATA-1:0] pc_o,
  output logic               halted_o
);

  logic [NB_DATA-1:0] pc;
  logic [NB_DATA-1:0] pc_next;
  logic [NB_DATA-1:0] pc_plus1;
  logic [NB_DATA-1:0] target;
  logic [NB_DATA-1:0] fetch_word;
  logic [NB_DATA-1:0] instr_next;
  logic [NB_DATA-1:0] pc_decode_next;
  logic               halted_next;
  logic               mem_wr_en;

  // The debug unit may only patch memory while the pipeline is frozen.
  assign mem_wr_en = imem_wr_en_i && !enable_i;

  instr_memory #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR)
  ) u_imem (
    .clk     (clock_i),
    .wr_en   (mem_wr_en),
    .wr_addr (imem_wr_addr_i),
    .wr_data (imem_wr_data_i),
    .rd_addr (pc[NB_ADDR-1:0]),
    .rd_data (fetch_word)
  );

  always_comb begin
    pc_plus1 = pc + NB_DATA'(1);
    case (pc_src_t'(pc_src))
      PC_SRC_SEQ:    target = pc_plus1;
      PC_SRC_BRANCH: target = address_branch;
      PC_SRC_JUMP:   target = address_jump;
      PC_SRC_REG:    target = address_register;
      default:       target = pc_plus1;
    endcase
  end

  always_comb begin
    pc_next        = pc;
    instr_next     = instruction_o;
    pc_decode_next = pc_decode_o;
    halted_next    = halted_o;
    if (halted_o || halt_signal) begin
      instr_next     = NOP_INSTR;
      pc_decode_next = '0;
      halted_next    = 1'b1;
    end else if (enable_i && !stall) begin
      if (pc_branch_or_jump) begin
        pc_next = target;
`ifdef DELAY_SLOT_EN
        instr_next     = fetch_word;
        pc_decode_next = pc_plus1;
`else
        instr_next     = NOP_INSTR;
        pc_decode_next = '0;
`endif
      end else begin
        pc_next        = pc_plus1;
        instr_next     = fetch_word;
        pc_decode_next = pc_plus1;
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      pc            <= '0;
      instruction_o <= NOP_INSTR;
      pc_decode_o   <= '0;
      halted_o      <= 1'b0;
    end else begin
      pc            <= pc_next;
      instruction_o <= instr_next;
      pc_decode_o   <= pc_decode_next;
      halted_o      <= halted_next;
    end
  end

  assign pc_o = pc;

endmodule

// File: tb/tb_fetch_top.sv
// Randomized scoreboard bench for fetch_top against a word-level reference model of the fetch rules.
module tb_fetch_top;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pcd;
    logic        halted;
  } exp_t;

  logic        clock_i;
  logic        reset_i;
  logic        enable_i;
  logic        stall;
  logic        pc_branch_or_jump;
  logic [1:0]  pc_src;
  logic [31:0] address_jump;
  logic [31:0] address_branch;
  logic [31:0] address_register;
  logic        halt_signal;
  logic        imem_wr_en_i;
  logic [9:0]  imem_wr_addr_i;
  logic [31:0] imem_wr_data_i;
  logic [31:0] instruction_o;
  logic [31:0] pc_decode_o;
  logic [31:0] pc_o;
  logic        halted_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] mmem [1024];
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pcd;
  logic        m_halt;
  exp_t        exp_q[$];
  exp_t        mon_e;

  fetch_top dut (
    .clock_i           (clock_i),
    .reset_i           (reset_i),
    .enable_i          (enable_i),
    .stall             (stall),
    .pc_branch_or_jump (pc_branch_or_jump),
    .pc_src            (pc_src),
    .address_jump      (address_jump),
    .address_branch    (address_branch),
    .address_register  (address_register),
    .halt_signal       (halt_signal),
    .imem_wr_en_i      (imem_wr_en_i),
    .imem_wr_addr_i    (imem_wr_addr_i),
    .imem_wr_data_i    (imem_wr_data_i),
    .instruction_o     (instruction_o),
    .pc_decode_o       (pc_decode_o),
    .pc_o              (pc_o),
    .halted_o          (halted_o)
  );

  initial begin
    clock_i = 1'b0;
    forever #5 clock_i = ~clock_i;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
    end
  endtask

  always @(negedge clock_i) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("pc", pc_o, mon_e.pc);
      chk("instr", instruction_o, mon_e.instr);
      chk("halted", {31'b0, halted_o}, {31'b0, mon_e.halted});
      if (!mon_e.halted) chk("pc_decode", pc_decode_o, mon_e.pcd);
    end
  end

  // Apply one cycle of inputs, advance the reference model, and wait past the edge.
  task automatic drive(input logic en, input logic st, input logic br, input logic [1:0] src,
                       input logic [31:0] ab, input logic [31:0] aj, input logic [31:0] ar,
                       input logic hs, input logic we, input logic [9:0] wa, input logic [31:0] wd);
    logic [31:0] fetched;
    logic [31:0] tgt;
    exp_t        e;
    enable_i = en; stall = st; pc_branch_or_jump = br; pc_src = src;
    address_branch = ab; address_jump = aj; address_register = ar;
    halt_signal = hs; imem_wr_en_i = we; imem_wr_addr_i = wa; imem_wr_data_i = wd;
    fetched = mmem[m_pc % 1024];
    if (m_halt || hs) begin
      m_halt  = 1'b1;
      m_instr = NOP;
      m_pcd   = 32'd0;
    end else if (en && !st) begin
      if (br) begin
        case (src)
          2'd0:    tgt = m_pc + 32'd1;
          2'd1:    tgt = ab;
          2'd2:    tgt = aj;
          default: tgt = ar;
        endcase
`ifdef DELAY_SLOT_EN
        m_instr = fetched;
        m_pcd   = m_pc + 32'd1;
`else
        m_instr = NOP;
        m_pcd   = 32'd0;
`endif
        m_pc = tgt;
      end else begin
        m_instr = fetched;
        m_pcd   = m_pc + 32'd1;
        m_pc    = m_pc + 32'd1;
      end
    end
    if (we && !en) mmem[wa] = wd;
    e.pc = m_pc; e.instr = m_instr; e.pcd = m_pcd; e.halted = m_halt;
    exp_q.push_back(e);
    @(posedge clock_i);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic mid_reset();
    @(negedge clock_i);
    #2 reset_i = 1'b0;
    #1;
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_halted", {31'b0, halted_o}, 32'd0);
    chk("rst_instr", instruction_o, NOP);
    chk("rst_pcd", pc_decode_o, 32'd0);
    m_pc = 0; m_instr = NOP; m_pcd = 0; m_halt = 0;
    #1 reset_i = 1'b1;
  endtask

  initial begin
    logic [31:0] d;
    reset_i = 1'b0;
    enable_i = 0; stall = 0; pc_branch_or_jump = 0; pc_src = 0;
    address_branch = 0; address_jump = 0; address_register = 0;
    halt_signal = 0; imem_wr_en_i = 0; imem_wr_addr_i = 0; imem_wr_data_i = 0;
    m_pc = 0; m_instr = NOP; m_pcd = 0; m_halt = 0;
    for (int i = 0; i < 1024; i++) mmem[i] = 32'd0;
    #3;
    chk("reset_pc", pc_o, 32'd0);
    chk("reset_instr", instruction_o, NOP);
    chk("reset_pcd", pc_decode_o, 32'd0);
    chk("reset_halted", {31'b0, halted_o}, 32'd0);
    #1 reset_i = 1'b1;

    // Load the whole memory through the debug port, with a small known program.
    for (int a = 0; a < 1024; a++) begin
      case (a)
        0: d = 32'h11;
        1: d = 32'h22;
        2: d = 32'h33;
        3: d = 32'h44;
        8: d = 32'hAB;
        default: d = $urandom;
      endcase
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 10'(a), d);
    end

    run(2);
    drive(1, 1, 1, 2'd2, 0, 32'h200, 0, 0, 0, 0, 0);
    drive(1, 1, 1, 2'd1, 32'h30, 0, 0, 0, 0, 0, 0);
    run(1);
    drive(1, 0, 1, 2'd1, 32'd8, 0, 0, 0, 0, 0, 0);
    run(1);
    drive(1, 0, 1, 2'd3, 0, 0, 32'h405, 0, 0, 0, 0);
    run(1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 10'd5, 32'hDEAD_BEEF);
    drive(1, 0, 1, 2'd3, 0, 0, 32'd5, 0, 0, 0, 0);
    run(1);
    drive(1, 0, 1, 2'd0, 0, 0, 0, 0, 0, 0, 0);
    run(2);

    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
            2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, 0,
            1'($urandom_range(0, 1)), 10'($urandom_range(16, 1023)), $urandom);
    end

    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, 0, 0, 0, 0);
    end
    mid_reset();
    run(5);

    @(negedge clock_i);
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
